// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution engine.
package conv_pkg;

  localparam int CONV_WIDTH = 8;

  typedef enum logic [2:0] {
    S_LOAD_F,
    S_LOAD_X,
    S_COMPUTE,
    S_DRAIN,
    S_OUTPUT
  } conv_state_e;

  // Clamp a signed value into the w-bit two's complement range.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Pipelined saturating MAC: saturated product register, then saturating accumulate.
module conv_mac
  import conv_pkg::*;
#(
  parameter int WIDTH   = CONV_WIDTH,
  parameter int RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_vld,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] f_in,
  input  logic                    acc_clr,
  output logic signed [WIDTH-1:0] y
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH:0]     sum;
  logic signed [WIDTH-1:0]   p_sat;
  logic signed [WIDTH-1:0]   p_reg;
  logic signed [WIDTH-1:0]   acc;
  logic signed [WIDTH-1:0]   acc_sat;
  logic                      p_vld;

  // Saturating each term keeps a clipped partial sum from wrapping on the next add.
  always_comb begin
    prod    = x_in * f_in;
    p_sat   = WIDTH'(sat_w(32'(prod), WIDTH));
    sum     = (WIDTH+1)'(acc) + (WIDTH+1)'(p_reg);
    acc_sat = WIDTH'(sat_w(32'(sum), WIDTH));
    y       = ((RELU_EN != 0) && (acc < 0)) ? '0 : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_vld <= 1'b0;
      p_reg <= '0;
      acc   <= '0;
    end else begin
      p_vld <= in_vld;
      if (in_vld) p_reg <= p_sat;
      if (acc_clr)    acc <= '0;
      else if (p_vld) acc <= acc_sat;
    end
  end

endmodule

// File: rtl/conv1d_stream.sv
// Streaming 1-D convolution: load filter, load input vector, emit one result per window.
// state     | meaning
// S_LOAD_F  | accept F_LEN filter taps
// S_LOAD_X  | accept X_LEN samples; f_valid at sample 0 reloads the filter
// S_COMPUTE | issue F_LEN tap reads for the current window
// S_DRAIN   | 2 cycles to flush read latency and product register
// S_OUTPUT  | hold y_valid/y_data until y_ready
module conv1d_stream
  import conv_pkg::*;
#(
  parameter int X_LEN   = 16,
  parameter int F_LEN   = 4,
  parameter int WIDTH   = CONV_WIDTH,
  parameter int STRIDE  = 1,
  parameter int RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] f_data,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic signed [WIDTH-1:0] x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [WIDTH-1:0] y_data,
  output logic                    y_valid,
  input  logic                    y_ready
);

  localparam int XW = $clog2(X_LEN);
  localparam int FW = $clog2(F_LEN);

  conv_state_e state, state_nx;

  logic [FW-1:0] f_cnt;
  logic [FW-1:0] k_cnt;
  logic [XW-1:0] x_cnt;
  logic [XW-1:0] win;
  logic [XW-1:0] rd_addr;
  logic          drain_cnt;
  logic          rd_vld;
  logic          f_hs, x_hs, y_hs;
  logic          f_last, x_last, k_last, win_last;

  logic signed [WIDTH-1:0] x_mem [X_LEN];
  logic signed [WIDTH-1:0] f_mem [F_LEN];
  logic signed [WIDTH-1:0] x_rd;
  logic signed [WIDTH-1:0] f_rd;

  assign f_hs     = f_valid & f_ready;
  assign x_hs     = x_valid & x_ready;
  assign y_hs     = y_valid & y_ready;
  assign f_last   = (f_cnt == FW'(F_LEN - 1));
  assign x_last   = (x_cnt == XW'(X_LEN - 1));
  assign k_last   = (k_cnt == FW'(F_LEN - 1));
  assign win_last = (win == XW'(X_LEN - F_LEN));
  assign rd_addr  = win + XW'(k_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD_F;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    f_ready  = 1'b0;
    x_ready  = 1'b0;
    y_valid  = 1'b0;
    unique case (state)
      S_LOAD_F: begin
        f_ready = 1'b1;
        if (f_valid && f_last) state_nx = S_LOAD_X;
      end
      S_LOAD_X: begin
        if (x_cnt == '0 && f_valid) begin
          state_nx = S_LOAD_F;
        end else begin
          x_ready = 1'b1;
          if (x_valid && x_last) state_nx = S_COMPUTE;
        end
      end
      S_COMPUTE: if (k_last) state_nx = S_DRAIN;
      S_DRAIN:   if (drain_cnt) state_nx = S_OUTPUT;
      S_OUTPUT: begin
        y_valid = 1'b1;
        if (y_ready) state_nx = win_last ? S_LOAD_X : S_COMPUTE;
      end
      default: state_nx = S_LOAD_F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_cnt     <= '0;
      x_cnt     <= '0;
      k_cnt     <= '0;
      win       <= '0;
      drain_cnt <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= (state == S_COMPUTE);
      if (f_hs) f_cnt <= f_last ? '0 : f_cnt + 1'b1;
      if (x_hs) x_cnt <= x_last ? '0 : x_cnt + 1'b1;
      if (x_hs && x_last) win <= '0;
      if (state == S_COMPUTE) k_cnt <= k_last ? '0 : k_cnt + 1'b1;
      if (state == S_DRAIN) drain_cnt <= ~drain_cnt;
      if (y_hs) win <= win_last ? '0 : win + XW'(STRIDE);
    end
  end

  // Storage needs no reset; rd_vld qualifies everything read out of it.
  always_ff @(posedge clk) begin
    if (f_hs) f_mem[f_cnt] <= f_data;
    if (x_hs) x_mem[x_cnt] <= x_data;
    x_rd <= x_mem[rd_addr];
    f_rd <= f_mem[k_cnt];
  end

  conv_mac #(
    .WIDTH  (WIDTH),
    .RELU_EN(RELU_EN)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .in_vld (rd_vld),
    .x_in   (x_rd),
    .f_in   (f_rd),
    .acc_clr(y_hs),
    .y      (y_data)
  );

endmodule

// File: tb/tb_conv1d_stream.sv
// Scoreboard bench for conv1d_stream, run on two configurations side by side.
module tb_conv1d_stream;

  localparam int X_LEN = 16;
  localparam int F_LEN = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void fail_now(string name, int act, int exp);
    n_total++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int STR   = (g == 0) ? 1 : 2;
    localparam int RELU  = (g == 0) ? 1 : 0;
    localparam int N_OUT = (X_LEN - F_LEN) / STR + 1;

    logic                    rst_n;
    logic signed [WIDTH-1:0] f_data, x_data, y_data;
    logic                    f_valid, f_ready, x_valid, x_ready, y_valid, y_ready;
    logic                    bp_en    = 1'b0;
    logic                    yr_force = 1'b1;
    logic                    done_b   = 1'b0;
    int                      cur_f [F_LEN];
    int                      cur_x [X_LEN];
    int                      exp_q [$];

    conv1d_stream #(
      .X_LEN(X_LEN), .F_LEN(F_LEN), .WIDTH(WIDTH), .STRIDE(STR), .RELU_EN(RELU)
    ) dut (
      .clk(clk), .reset(rst_n),
      .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
    );

    function automatic string nm(string s);
      return $sformatf("cfg%0d %s", g, s);
    endfunction

    function automatic int sat(int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
    endfunction

    // Reference: sum of per-term-saturated products, clipped after every addition.
    function automatic int ref_y(int w);
      int acc = 0;
      for (int k = 0; k < F_LEN; k++)
        acc = sat(acc + sat(cur_f[k] * cur_x[w * STR + k]));
      if (RELU != 0 && acc < 0) acc = 0;
      return acc;
    endfunction

    function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
      y_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        y_ready = bp_en ? ($urandom_range(0, 3) != 0) : yr_force;
      end
    end

    initial begin
      logic                    pend;
      logic signed [WIDTH-1:0] held;
      pend = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pend = 1'b0;
        end else begin
          if (pend) begin
            check(nm("hold y_valid"), int'(y_valid), 1);
            check(nm("hold y_data"), int'(y_data), int'(held));
          end
          if (y_valid && y_ready) begin
            if (exp_q.size() == 0) fail_now(nm("unexpected y_data"), int'(y_data), 0);
            else check(nm("y_data"), int'(y_data), exp_q.pop_front());
          end
          pend = y_valid && !y_ready;
          held = y_data;
        end
      end
    end

    task automatic send_f(int v);
      int t;
      f_data  = WIDTH'(v);
      f_valid = 1'b1;
      for (t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (f_ready) break;
      end
      if (t == 2000) fail_now(nm("f_ready timeout"), 0, 1);
      @(posedge clk);
      #1;
      f_valid = 1'b0;
    endtask

    task automatic send_x(int v);
      int t;
      x_data  = WIDTH'(v);
      x_valid = 1'b1;
      for (t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (x_ready) break;
      end
      if (t == 2000) fail_now(nm("x_ready timeout"), 0, 1);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
    endtask

    task automatic load_filter();
      for (int k = 0; k < F_LEN; k++) send_f(cur_f[k]);
    endtask

    task automatic run_vec();
      for (int w = 0; w < N_OUT; w++) exp_q.push_back(ref_y(w));
      for (int i = 0; i < X_LEN; i++) send_x(cur_x[i]);
    endtask

    task automatic wait_idle();
      int t;
      for (t = 0; t < 5000; t++) begin
        @(posedge clk);
        if (exp_q.size() == 0) break;
      end
      if (t == 5000) fail_now(nm("drain timeout"), exp_q.size(), 0);
      #1;
      check(nm("idle x_ready"), int'(x_ready), 1);
      check(nm("idle f_ready"), int'(f_ready), 0);
    endtask

    task automatic check_reset_outputs(string tag);
      check(nm({tag, " f_ready"}), int'(f_ready), 1);
      check(nm({tag, " x_ready"}), int'(x_ready), 0);
      check(nm({tag, " y_valid"}), int'(y_valid), 0);
      check(nm({tag, " y_data"}), int'(y_data), 0);
    endtask

    initial begin
      rst_n   = 1'b0;
      f_valid = 1'b0;
      x_valid = 1'b0;
      f_data  = '0;
      x_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Ramp data: 10w+20 style results with saturation at the tail.
      cur_f = '{1, 2, 3, 4};
      for (int i = 0; i < X_LEN; i++) cur_x[i] = i;
      load_filter();
      run_vec();
      wait_idle();

      // Filter reload from idle LOAD_X; sample intake must be blocked meanwhile.
      f_data  = -8'sd1;
      f_valid = 1'b1;
      #1;
      check(nm("reload x_ready"), int'(x_ready), 0);
      cur_f = '{-1, -1, -1, -1};
      for (int i = 0; i < X_LEN; i++) cur_x[i] = 10;
      load_filter();
      run_vec();
      wait_idle();

      cur_f = '{100, 0, 0, 0};
      for (int i = 0; i < X_LEN; i++) cur_x[i] = 100;
      load_filter();
      run_vec();
      wait_idle();

      cur_f = '{-128, -128, -128, -128};
      for (int i = 0; i < X_LEN; i++) cur_x[i] = -128;
      load_filter();
      run_vec();
      wait_idle();

      // Stall OUTPUT while offering filter words that must be ignored.
      for (int k = 0; k < F_LEN; k++) cur_f[k] = int'($urandom_range(0, 15)) - 8;
      load_filter();
      yr_force = 1'b0;
      for (int i = 0; i < X_LEN; i++) cur_x[i] = rnd8();
      run_vec();
      f_data  = 8'sd55;
      f_valid = 1'b1;
      repeat (30) begin
        @(negedge clk);
        check(nm("busy f_ready"), int'(f_ready), 0);
      end
      @(posedge clk);
      #1;
      f_valid  = 1'b0;
      yr_force = 1'b1;
      wait_idle();
      for (int i = 0; i < X_LEN; i++) cur_x[i] = rnd8();
      run_vec();
      wait_idle();

      bp_en = 1'b1;
      for (int v = 0; v < 8; v++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int k = 0; k < F_LEN; k++)
            cur_f[k] = (v < 4) ? int'($urandom_range(0, 31)) - 16 : rnd8();
          load_filter();
        end
        for (int i = 0; i < X_LEN; i++) cur_x[i] = rnd8();
        run_vec();
        wait_idle();
      end
      bp_en    = 1'b0;
      yr_force = 1'b1;

      // Async reset landing inside COMPUTE, then a full reload.
      for (int i = 0; i < X_LEN; i++) cur_x[i] = rnd8();
      run_vec();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("mid reset");
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < F_LEN; k++) cur_f[k] = int'($urandom_range(0, 31)) - 16;
      load_filter();
      for (int i = 0; i < X_LEN; i++) cur_x[i] = rnd8();
      run_vec();
      wait_idle();

      done_b = 1'b1;
    end
  end

  initial begin
    wait (cfg[0].done_b && cfg[1].done_b);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got %0d finished configs expected %0d", int'(cfg[0].done_b) + int'(cfg[1].done_b), 2);
    $fatal(1, "simulation time limit reached");
  end

endmodule
